// File: rtl/magnitude_stats_tracker_if.sv
// Sample/statistics bundle between the magnitude stage, the tracker and the status/output mux.
// The master drives samples and control; the slave (the tracker) returns the statistics.
interface magnitude_stats_tracker_if #(
    parameter int WIDTH = 8
) ();
    logic             mag_valid;
    logic [WIDTH-1:0] mag_in;
    logic [WIDTH-1:0] thr_in;
    logic             clr;
    logic [WIDTH-1:0] avg_out;
    logic             avg_valid;
    logic [WIDTH-1:0] peak_out;
    logic             above;
    logic             cross_pulse;
    logic [7:0]       event_cnt;

    modport master (
        output mag_valid, mag_in, thr_in, clr,
        input  avg_out, avg_valid, peak_out, above, cross_pulse, event_cnt
    );

    modport slave (
        input  mag_valid, mag_in, thr_in, clr,
        output avg_out, avg_valid, peak_out, above, cross_pulse, event_cnt
    );
endinterface

// File: rtl/magnitude_stats_tracker.sv
// Moving average, peak hold and hysteretic threshold detector over magnitude samples.
// Statistics advance only on accepted samples (mag_valid & ~clr); clr and rst_n wipe all history.
//
// state | meaning
// BELOW | waiting for a sample at or above thr_in
// ABOVE | detected; leaves only on a sample below thr_in - HYST
module magnitude_stats_tracker #(
    parameter int WIDTH    = 8,
    parameter int AVG_LOG2 = 3,
    parameter int HYST     = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    magnitude_stats_tracker_if.slave bus
);
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = WIDTH + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    typedef enum logic {BELOW = 1'b0, ABOVE = 1'b1} state_t;

    state_t               state, state_next;
    logic                 cross_set;
    logic                 accept;
    logic [WIDTH-1:0]     lo;

    logic [WIDTH-1:0]     sample_mem [DEPTH];
    logic [AVG_LOG2-1:0]  wr_ptr;
    logic [FILL_W-1:0]    fill_cnt;
    logic [FILL_W-1:0]    fill_next;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     sum_next;

    logic [WIDTH-1:0]     avg_reg;
    logic                 avg_valid_reg;
    logic [WIDTH-1:0]     peak_reg;
    logic                 cross_reg;
    logic [7:0]           event_reg;

    assign accept = bus.mag_valid & ~bus.clr;
    assign lo     = (bus.thr_in > WIDTH'(HYST)) ? bus.thr_in - WIDTH'(HYST) : '0;

    // The evicted slot is zero until the window has filled once, so the sum never overflows.
    assign sum_next  = sum - SUM_W'(sample_mem[wr_ptr]) + SUM_W'(bus.mag_in);
    assign fill_next = (fill_cnt == FILL_W'(DEPTH)) ? fill_cnt : fill_cnt + 1'b1;

    always_comb begin
        state_next = state;
        cross_set  = 1'b0;
        if (accept) begin
            case (state)
                BELOW: begin
                    if (bus.mag_in >= bus.thr_in) begin
                        state_next = ABOVE;
                        cross_set  = 1'b1;
                    end
                end
                ABOVE: begin
                    if (bus.mag_in < lo) begin
                        state_next = BELOW;
                    end
                end
                default: state_next = BELOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BELOW;
        end else if (bus.clr) begin
            state <= BELOW;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sample_mem[i] <= '0;
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            sum           <= '0;
            avg_reg       <= '0;
            avg_valid_reg <= 1'b0;
            peak_reg      <= '0;
            cross_reg     <= 1'b0;
            event_reg     <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) sample_mem[i] <= '0;
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            sum           <= '0;
            avg_reg       <= '0;
            avg_valid_reg <= 1'b0;
            peak_reg      <= '0;
            cross_reg     <= 1'b0;
            event_reg     <= '0;
        end else begin
            cross_reg <= cross_set;
            if (accept) begin
                sample_mem[wr_ptr] <= bus.mag_in;
                wr_ptr             <= wr_ptr + 1'b1;
                fill_cnt           <= fill_next;
                sum                <= sum_next;
                avg_reg            <= sum_next[SUM_W-1:AVG_LOG2];
                avg_valid_reg      <= (fill_next == FILL_W'(DEPTH));
                if (bus.mag_in > peak_reg) begin
                    peak_reg <= bus.mag_in;
                end
                if (cross_set && (event_reg != 8'hFF)) begin
                    event_reg <= event_reg + 8'd1;
                end
            end
        end
    end

    assign bus.avg_out     = avg_reg;
    assign bus.avg_valid   = avg_valid_reg;
    assign bus.peak_out    = peak_reg;
    assign bus.above       = (state == ABOVE);
    assign bus.cross_pulse = cross_reg;
    assign bus.event_cnt   = event_reg;
endmodule
